lockin_photon_counter: RTL and testbench

- Multi-channel successor to the single-PMT fluorescence counter.
- Drives the modulated light source and counts PMT pulses on N_CH channels synchronously with it: up while light is on, down while off.
- Adds input synchronisation, post-edge blanking, signed saturating counts, a valid/ready result handshake with overrun flag, and runtime-programmable period and integration time.
- Sits between the PMT GPIO inputs and the readout/display logic.

---
 rtl/lockin_pkg.sv | 26 ++
 rtl/pmt_edge_detect.sv | 28 ++
 rtl/lockin_photon_counter.sv | 177 +++++++++++++++++
 tb/tb_lockin_photon_counter.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/lockin_pkg.sv
// Shared constants and saturating count helpers for the lock-in photon counter.
package lockin_pkg;

  localparam int unsigned CNT_W        = 32;
  localparam int unsigned TMR_W        = 32;
  localparam int unsigned MIN_PERIOD   = 2;
  localparam int unsigned MIN_INT_TIME = 1;
  localparam int unsigned SAT_W        = 64;

  // +1 on a signed value of width w (<= SAT_W), clamped at the positive limit.
  function automatic logic signed [SAT_W-1:0] sat_inc(input logic signed [SAT_W-1:0] v,
                                                      input int unsigned w);
    logic signed [SAT_W-1:0] max_v;
    max_v = (64'sd1 <<< (w - 32'd1)) - 64'sd1;
    return (v >= max_v) ? max_v : v + 64'sd1;
  endfunction

  // -1 on a signed value of width w (<= SAT_W), clamped at the negative limit.
  function automatic logic signed [SAT_W-1:0] sat_dec(input logic signed [SAT_W-1:0] v,
                                                      input int unsigned w);
    logic signed [SAT_W-1:0] min_v;
    min_v = -(64'sd1 <<< (w - 32'd1));
    return (v <= min_v) ? min_v : v - 64'sd1;
  endfunction

endpackage

// File: rtl/pmt_edge_detect.sv
// Synchronises one asynchronous PMT input and flags each rising edge for one cycle.
module pmt_edge_detect #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clock_50_mhz,
  input  logic reset,
  input  logic pmt_in,
  output logic edge_pulse
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   last_q;

  // Synchroniser chain plus one delayed copy for edge detection.
  always_ff @(posedge clock_50_mhz or posedge reset) begin
    if (reset) begin
      sync_q <= '0;
      last_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pmt_in};
      last_q <= sync_q[SYNC_STAGES-1];
    end
  end

  // Combinational so the count lands one cycle after the synchroniser output rises.
  assign edge_pulse = sync_q[SYNC_STAGES-1] & ~last_q;

endmodule

// File: rtl/lockin_photon_counter.sv
// Multi-channel lock-in photon counter: drives the light source, counts PMT edges
// up while lit and down while dark, and hands out per-window snapshots.
module lockin_photon_counter #(
  parameter int unsigned N_CH         = 4,
  parameter int unsigned CNT_W        = lockin_pkg::CNT_W,
  parameter int unsigned TMR_W        = lockin_pkg::TMR_W,
  parameter int unsigned BLANK_CYCLES = 8,
  parameter int unsigned SYNC_STAGES  = 2
) (
  input  logic                  clock_50_mhz,
  input  logic                  reset,
  input  logic                  enable,
  input  logic [N_CH-1:0]       pmt_in,
  input  logic [TMR_W-1:0]      light_modulation_period,
  input  logic [TMR_W-1:0]      integration_time,
  output logic                  light_source_pin,
  output logic [N_CH*CNT_W-1:0] result_data,
  output logic                  result_valid,
  input  logic                  result_ready,
  output logic                  result_overrun,
  output logic [N_CH-1:0]       pulse_out_pin
);
  import lockin_pkg::*;

  localparam int unsigned BLANK_W = (BLANK_CYCLES > 0) ? $clog2(BLANK_CYCLES + 1) : 1;

  logic [TMR_W-1:0]   mod_timer_q, mod_timer_d;
  logic [TMR_W-1:0]   per_q, per_d;
  logic [TMR_W-1:0]   int_timer_q, int_timer_d;
  logic [TMR_W-1:0]   int_len_q, int_len_d;
  logic               light_q, light_d;
  logic [BLANK_W-1:0] blank_q, blank_d;
  logic               valid_q, valid_d;
  logic               overrun_q, overrun_d;

  logic               toggle_c, snap_c, xfer_c, count_en_c;
  logic [TMR_W-1:0]   per_in_c, int_in_c;
  logic [N_CH-1:0]    edge_c;

  // Clamp the programmed half-period and window length to their minimums.
  assign per_in_c = (light_modulation_period < TMR_W'(MIN_PERIOD)) ?
                    TMR_W'(MIN_PERIOD) : light_modulation_period;
  assign int_in_c = (integration_time < TMR_W'(MIN_INT_TIME)) ?
                    TMR_W'(MIN_INT_TIME) : integration_time;

  // Modulation, blanking and integration timers; idle while enable is low.
  always_comb begin
    mod_timer_d = mod_timer_q;
    per_d       = per_q;
    int_timer_d = int_timer_q;
    int_len_d   = int_len_q;
    light_d     = light_q;
    blank_d     = blank_q;
    toggle_c    = 1'b0;
    snap_c      = 1'b0;
    if (!enable) begin
      mod_timer_d = '0;
      int_timer_d = '0;
      light_d     = 1'b0;
      blank_d     = '0;
      per_d       = per_in_c;
      int_len_d   = int_in_c;
    end else begin
      toggle_c = (mod_timer_q == per_q - TMR_W'(1));
      snap_c   = (int_timer_q == int_len_q - TMR_W'(1));
      if (blank_q != '0) blank_d = blank_q - BLANK_W'(1);
      if (toggle_c) begin
        mod_timer_d = '0;
        light_d     = ~light_q;
        per_d       = per_in_c;
        blank_d     = BLANK_W'(BLANK_CYCLES);
      end else begin
        mod_timer_d = mod_timer_q + TMR_W'(1);
      end
      if (snap_c) begin
        int_timer_d = '0;
        int_len_d   = int_in_c;
      end else begin
        int_timer_d = int_timer_q + TMR_W'(1);
      end
    end
  end

  assign count_en_c = enable & (blank_q == '0);
  assign xfer_c     = valid_q & result_ready;

  // Result handshake: a snapshot wins over a same-cycle transfer; overrun is sticky.
  always_comb begin
    valid_d   = valid_q;
    overrun_d = overrun_q;
    if (xfer_c) begin
      valid_d   = 1'b0;
      overrun_d = 1'b0;
    end
    if (snap_c) begin
      valid_d = 1'b1;
      if (valid_q && !xfer_c) overrun_d = 1'b1;
    end
  end

  // Shared timer and handshake state.
  always_ff @(posedge clock_50_mhz or posedge reset) begin
    if (reset) begin
      mod_timer_q <= '0;
      per_q       <= TMR_W'(2);
      int_timer_q <= '0;
      int_len_q   <= TMR_W'(2);
      light_q     <= 1'b0;
      blank_q     <= '0;
      valid_q     <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      mod_timer_q <= mod_timer_d;
      per_q       <= per_d;
      int_timer_q <= int_timer_d;
      int_len_q   <= int_len_d;
      light_q     <= light_d;
      blank_q     <= blank_d;
      valid_q     <= valid_d;
      overrun_q   <= overrun_d;
    end
  end

  assign light_source_pin = light_q;
  assign result_valid     = valid_q;
  assign result_overrun   = overrun_q;

  for (genvar ch = 0; ch < N_CH; ch++) begin : g_ch
    logic signed [CNT_W-1:0] cnt_q, cnt_d, cnt_upd_c;
    logic signed [CNT_W-1:0] data_q, data_d;
    logic [CNT_W-1:0]        drain_q, drain_d;
    logic                    pulse_q;

    pmt_edge_detect #(
      .SYNC_STAGES(SYNC_STAGES)
    ) u_edge (
      .clock_50_mhz(clock_50_mhz),
      .reset       (reset),
      .pmt_in      (pmt_in[ch]),
      .edge_pulse  (edge_c[ch])
    );

    // Count including this cycle's edge; feeds both the counter and the snapshot.
    always_comb begin
      cnt_upd_c = cnt_q;
      if (edge_c[ch] && count_en_c) begin
        cnt_upd_c = light_q ? CNT_W'(sat_inc(64'(cnt_q), CNT_W))
                            : CNT_W'(sat_dec(64'(cnt_q), CNT_W));
      end
      cnt_d   = (snap_c || !enable) ? '0 : cnt_upd_c;
      data_d  = snap_c ? cnt_upd_c : data_q;
      drain_d = drain_q;
      if (!enable)              drain_d = '0;
      else if (snap_c)          drain_d = cnt_upd_c[CNT_W-1] ? '0 : $unsigned(cnt_upd_c);
      else if (drain_q != '0)   drain_d = drain_q - CNT_W'(1);
    end

    // Per-channel count, snapshot and pulse-length drain registers.
    always_ff @(posedge clock_50_mhz or posedge reset) begin
      if (reset) begin
        cnt_q   <= '0;
        data_q  <= '0;
        drain_q <= '0;
        pulse_q <= 1'b0;
      end else begin
        cnt_q   <= cnt_d;
        data_q  <= data_d;
        drain_q <= drain_d;
        pulse_q <= (drain_d != '0);
      end
    end

    assign result_data[ch*CNT_W +: CNT_W] = data_q;
    assign pulse_out_pin[ch]              = pulse_q;
  end

endmodule

// File: tb/tb_lockin_photon_counter.sv
// Directed bench for lockin_photon_counter (8-bit counts to reach saturation quickly).
module tb_lockin_photon_counter;

  localparam int unsigned N_CH = 4;
  localparam int unsigned CW   = 8;
  localparam int unsigned TW   = 32;

  logic               clk;
  logic               rst;
  logic               enable;
  logic [N_CH-1:0]    pmt;
  logic [TW-1:0]      period;
  logic [TW-1:0]      itime;
  logic               light;
  logic [N_CH*CW-1:0] rdata;
  logic               rvalid;
  logic               rready;
  logic               overrun;
  logic [N_CH-1:0]    pout;

  int errors;
  int checks;
  int cyc;

  lockin_photon_counter #(
    .N_CH(N_CH), .CNT_W(CW), .TMR_W(TW), .BLANK_CYCLES(8), .SYNC_STAGES(2)
  ) dut (
    .clock_50_mhz           (clk),
    .reset                  (rst),
    .enable                 (enable),
    .pmt_in                 (pmt),
    .light_modulation_period(period),
    .integration_time       (itime),
    .light_source_pin       (light),
    .result_data            (rdata),
    .result_valid           (rvalid),
    .result_ready           (rready),
    .result_overrun         (overrun),
    .pulse_out_pin          (pout)
  );

  initial begin
    clk = 1'b0;
    forever #10 clk = ~clk;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [CW-1:0] ch_val(input int ch);
    return rdata[ch*CW +: CW];
  endfunction

  // Advance to 1 ns after the next rising edge: the start of cycle cyc+1.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic tick_to(input int c);
    while (cyc < c) tick();
  endtask

  // Pin pulse timed so the detected edge is counted in cycle ce.
  task automatic edge_at(input int ch, input int ce);
    tick_to(ce - 2);
    pmt[ch] = 1'b1;
    tick();
    pmt[ch] = 1'b0;
  endtask

  // Idle briefly so the new period/time are sampled, then enable: next cycle is cycle 0.
  task automatic start_run(input int p, input int t);
    enable = 1'b0;
    period = TW'(p);
    itime  = TW'(t);
    tick();
    tick();
    enable = 1'b1;
    cyc    = 0;
  endtask

  task automatic accept();
    rready = 1'b1;
    tick();
    rready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick(); tick();
    checks++; if (light !== 1'b0) begin errors++; $display("FAIL rst_light: got %b expected 0", light); end
    checks++; if (rvalid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b expected 0", rvalid); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL rst_overrun: got %b expected 0", overrun); end
    checks++; if (rdata !== '0) begin errors++; $display("FAIL rst_data: got %h expected 0", rdata); end
    checks++; if (pout !== '0) begin errors++; $display("FAIL rst_pulse: got %b expected 0", pout); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_light_only();
    int hi;
    int hi_other;
    start_run(100, 1000);
    for (int i = 0; i < 10; i++) edge_at(0, 110 + 5 * i);
    tick_to(160);
    checks++; if (light !== 1'b1) begin errors++; $display("FAIL lo_light_on: got %b expected 1", light); end
    tick_to(200);
    checks++; if (light !== 1'b0) begin errors++; $display("FAIL lo_light_off: got %b expected 0", light); end
    tick_to(999);
    checks++; if (rvalid !== 1'b0) begin errors++; $display("FAIL lo_early_valid: got %b expected 0", rvalid); end
    tick();
    checks++; if (rvalid !== 1'b1) begin errors++; $display("FAIL lo_valid: got %b expected 1", rvalid); end
    checks++; if (ch_val(0) !== 8'd10) begin errors++; $display("FAIL lo_ch0: got %0d expected 10", ch_val(0)); end
    checks++; if (rdata[N_CH*CW-1:CW] !== '0) begin errors++; $display("FAIL lo_others: got %h expected 0", rdata[N_CH*CW-1:CW]); end
    hi = 0;
    hi_other = 0;
    for (int i = 0; i < 20; i++) begin
      if (pout[0]) hi++;
      if (pout[3:1] != 3'b000) hi_other++;
      tick();
    end
    checks++; if (hi !== 10) begin errors++; $display("FAIL lo_pulse_len: got %0d expected 10", hi); end
    checks++; if (hi_other !== 0) begin errors++; $display("FAIL lo_pulse_other: got %0d expected 0", hi_other); end
    accept();
    checks++; if (rvalid !== 1'b0) begin errors++; $display("FAIL lo_accept_valid: got %b expected 0", rvalid); end
  endtask

  task automatic test_background_blanking();
    int hi;
    start_run(100, 1000);
    edge_at(2, 103);
    edge_at(2, 108);
    for (int i = 0; i < 5; i++) edge_at(1, 110 + 10 * i);
    for (int i = 0; i < 7; i++) edge_at(1, 210 + 10 * i);
    edge_at(1, 303);
    tick_to(1000);
    checks++; if (rvalid !== 1'b1) begin errors++; $display("FAIL bg_valid: got %b expected 1", rvalid); end
    checks++; if (ch_val(1) !== 8'hFE) begin errors++; $display("FAIL bg_ch1: got %h expected fe", ch_val(1)); end
    checks++; if (ch_val(2) !== 8'h01) begin errors++; $display("FAIL bg_ch2_blank: got %h expected 01", ch_val(2)); end
    checks++; if (ch_val(0) !== 8'h00) begin errors++; $display("FAIL bg_ch0: got %h expected 00", ch_val(0)); end
    checks++; if (pout[2] !== 1'b1) begin errors++; $display("FAIL bg_pulse2_on: got %b expected 1", pout[2]); end
    hi = 0;
    for (int i = 0; i < 6; i++) begin
      if (pout[1]) hi++;
      tick();
    end
    checks++; if (hi !== 0) begin errors++; $display("FAIL bg_pulse1: got %0d expected 0", hi); end
    checks++; if (pout[2] !== 1'b0) begin errors++; $display("FAIL bg_pulse2_off: got %b expected 0", pout[2]); end
    accept();
  endtask

  task automatic test_saturation();
    start_run(1000, 2000);
    for (int i = 0; i < 200; i++) edge_at(0, 1010 + 2 * i);
    tick_to(2000);
    checks++; if (rvalid !== 1'b1) begin errors++; $display("FAIL sat_pos_valid: got %b expected 1", rvalid); end
    checks++; if (ch_val(0) !== 8'h7F) begin errors++; $display("FAIL sat_pos: got %h expected 7f", ch_val(0)); end
    accept();
    for (int i = 0; i < 200; i++) edge_at(0, 2010 + 2 * i);
    tick_to(4000);
    checks++; if (ch_val(0) !== 8'h80) begin errors++; $display("FAIL sat_neg: got %h expected 80", ch_val(0)); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL sat_overrun: got %b expected 0", overrun); end
    accept();
  endtask

  task automatic test_handshake();
    start_run(100, 50);
    edge_at(3, 20);
    tick_to(50);
    checks++; if (rvalid !== 1'b1) begin errors++; $display("FAIL hs_valid1: got %b expected 1", rvalid); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL hs_no_overrun1: got %b expected 0", overrun); end
    checks++; if (ch_val(3) !== 8'hFF) begin errors++; $display("FAIL hs_data1: got %h expected ff", ch_val(3)); end
    edge_at(3, 60);
    edge_at(3, 70);
    tick_to(100);
    checks++; if (rvalid !== 1'b1) begin errors++; $display("FAIL hs_valid2: got %b expected 1", rvalid); end
    checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL hs_overrun: got %b expected 1", overrun); end
    checks++; if (ch_val(3) !== 8'hFE) begin errors++; $display("FAIL hs_data2: got %h expected fe", ch_val(3)); end
    accept();
    checks++; if (rvalid !== 1'b0) begin errors++; $display("FAIL hs_xfer_valid: got %b expected 0", rvalid); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL hs_xfer_overrun: got %b expected 0", overrun); end
    edge_at(0, 115);
    tick_to(150);
    checks++; if (ch_val(0) !== 8'h01) begin errors++; $display("FAIL hs_data3: got %h expected 01", ch_val(0)); end
    edge_at(0, 160);
    edge_at(0, 170);
    tick_to(199);
    accept();
    checks++; if (rvalid !== 1'b1) begin errors++; $display("FAIL hs_coincide_valid: got %b expected 1", rvalid); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL hs_coincide_overrun: got %b expected 0", overrun); end
    checks++; if (ch_val(0) !== 8'h02) begin errors++; $display("FAIL hs_coincide_data: got %h expected 02", ch_val(0)); end
    accept();
    checks++; if (rvalid !== 1'b0) begin errors++; $display("FAIL hs_final_valid: got %b expected 0", rvalid); end
  endtask

  task automatic test_terminal_edge();
    start_run(100, 60);
    edge_at(2, 59);
    edge_at(2, 61);
    checks++; if (rvalid !== 1'b1) begin errors++; $display("FAIL te_valid: got %b expected 1", rvalid); end
    checks++; if (ch_val(2) !== 8'hFF) begin errors++; $display("FAIL te_included: got %h expected ff", ch_val(2)); end
    accept();
    checks++; if (rvalid !== 1'b0) begin errors++; $display("FAIL te_accept: got %b expected 0", rvalid); end
    tick_to(120);
    checks++; if (rvalid !== 1'b1) begin errors++; $display("FAIL te_valid2: got %b expected 1", rvalid); end
    checks++; if (ch_val(2) !== 8'hFF) begin errors++; $display("FAIL te_next_window: got %h expected ff", ch_val(2)); end
    accept();
  endtask

  task automatic test_reset_mid_window();
    start_run(100, 1000);
    edge_at(0, 150);
    tick_to(500);
    checks++; if (light !== 1'b1) begin errors++; $display("FAIL rm_light_before: got %b expected 1", light); end
    rst    = 1'b1;
    enable = 1'b0;
    #1;
    checks++; if (light !== 1'b0) begin errors++; $display("FAIL rm_light: got %b expected 0", light); end
    checks++; if (rvalid !== 1'b0) begin errors++; $display("FAIL rm_valid: got %b expected 0", rvalid); end
    checks++; if (rdata !== '0) begin errors++; $display("FAIL rm_data: got %h expected 0", rdata); end
    tick(); tick();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    checks++; if (rvalid !== 1'b0) begin errors++; $display("FAIL rm_no_result: got %b expected 0", rvalid); end
  endtask

  task automatic test_enable_toggle();
    start_run(100, 300);
    edge_at(0, 150);
    tick_to(160);
    checks++; if (light !== 1'b1) begin errors++; $display("FAIL en_light_on: got %b expected 1", light); end
    enable = 1'b0;
    tick();
    checks++; if (light !== 1'b0) begin errors++; $display("FAIL en_light_idle: got %b expected 0", light); end
    tick(); tick(); tick();
    enable = 1'b1;
    cyc    = 0;
    edge_at(0, 150);
    tick_to(299);
    checks++; if (rvalid !== 1'b0) begin errors++; $display("FAIL en_full_window: got %b expected 0", rvalid); end
    tick();
    checks++; if (rvalid !== 1'b1) begin errors++; $display("FAIL en_valid: got %b expected 1", rvalid); end
    checks++; if (ch_val(0) !== 8'h01) begin errors++; $display("FAIL en_cleared: got %h expected 01", ch_val(0)); end
    accept();
  endtask

  initial begin
    errors = 0;
    checks = 0;
    cyc    = 0;
    rst    = 1'b1;
    enable = 1'b0;
    pmt    = '0;
    period = TW'(100);
    itime  = TW'(1000);
    rready = 1'b0;
    test_reset();
    test_light_only();
    test_background_blanking();
    test_saturation();
    test_handshake();
    test_terminal_edge();
    test_reset_mid_window();
    test_enable_toggle();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
